alu_requester: RTL

ALU_REQUESTER -- requirements
Module: alu_requester

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_req_timer.sv | 48 ++++
 rtl/alu_requester.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the ALU requester:
//   alu_op_e    - ALU operation encoding (ADD, SUB, MUL, DIV)
//   state_e     - requester FSM states
//   DIV0_RESULT - result reported for a divide by zero (no ALU issue)
// ----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_RESP  = 2'b11
  } state_e;

  localparam logic [7:0] DIV0_RESULT = 8'hFF;

endpackage

// File: rtl/alu_req_timer.sv
// ----------------------------------------------------------------------------
// alu_req_timer
// WAIT-state watchdog for the ALU requester. Only instantiated when the
// ALU_REQ_TIMEOUT_EN macro is defined.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - zero the count (asserted on the cycle before WAIT entry)
//   en        - count this cycle (asserted while in WAIT)
//   expired   - high on the TIMEOUT_CYCLES-th consecutive counted cycle
// ----------------------------------------------------------------------------
module alu_req_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count starts at 0 in the first WAIT cycle, so reaching LAST marks
  // the TIMEOUT_CYCLES-th WAIT cycle without an ALU response.
  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/alu_requester.sv
// ----------------------------------------------------------------------------
// alu_requester
// Accepts one command at a time, issues it to a multi-cycle ALU, waits for the
// ALU result and presents it downstream with a valid/ready handshake.
// Divide by zero is answered locally (res_data=8'hFF, res_err=1).
// Optional feature: define ALU_REQ_TIMEOUT_EN to abort a transaction after
// TIMEOUT_CYCLES WAIT cycles without an ALU response (res_data=0, res_err=1).
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      - upstream command handshake
//   cmd_a, cmd_b, cmd_op     - operands and operation
//   in, op_codes, valid      - ALU operand bus {A,B}, op select, start strobe
//   o, ready                 - ALU result and result-valid
//   res_valid/res_ready      - downstream result handshake
//   res_data, res_op, res_err- captured result, echoed opcode, error flag
//   issued_cnt               - number of transactions issued to the ALU
// ----------------------------------------------------------------------------
module alu_requester
  import alu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [1:0]  cmd_op,
  output logic [15:0] in,
  output logic [1:0]  op_codes,
  output logic        valid,
  input  logic [7:0]  o,
  input  logic        ready,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data,
  output logic [1:0]  res_op,
  output logic        res_err,
  output logic [15:0] issued_cnt
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("alu_requester: TIMEOUT_CYCLES must be at least 1");
  end

  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  alu_op_e     op_q, op_d;
  logic [7:0]  res_data_q, res_data_d;
  logic [1:0]  res_op_q, res_op_d;
  logic        res_err_q, res_err_d;
  logic [15:0] issued_cnt_q, issued_cnt_d;
  logic        timed_out;

`ifdef ALU_REQ_TIMEOUT_EN
  logic timer_clear;
  logic timer_en;

  // Clearing in ISSUE means the count is fresh on every WAIT entry.
  assign timer_clear = (state_q == S_ISSUE);
  assign timer_en    = (state_q == S_WAIT);

  alu_req_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .en     (timer_en),
    .expired(timed_out)
  );
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    res_data_d   = res_data_q;
    res_op_d     = res_op_q;
    res_err_d    = res_err_q;
    issued_cnt_d = issued_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          a_d      = cmd_a;
          b_d      = cmd_b;
          op_d     = alu_op_e'(cmd_op);
          res_op_d = cmd_op;
          // Divide by zero never reaches the ALU; answer it directly.
          if ((alu_op_e'(cmd_op) == OP_DIV) && (cmd_b == 8'd0)) begin
            res_data_d = DIV0_RESULT;
            res_err_d  = 1'b1;
            state_d    = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        issued_cnt_d = issued_cnt_q + 16'd1;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        // A real ALU response wins over a coincident timeout.
        if (ready) begin
          res_data_d = o;
          res_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (timed_out) begin
          res_data_d = 8'd0;
          res_err_d  = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OP_ADD;
      res_data_q   <= '0;
      res_op_q     <= '0;
      res_err_q    <= 1'b0;
      issued_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      res_data_q   <= res_data_d;
      res_op_q     <= res_op_d;
      res_err_q    <= res_err_d;
      issued_cnt_q <= issued_cnt_d;
    end
  end

  // cmd_ready is also gated by rst so nothing is accepted while reset is held.
  assign cmd_ready  = (state_q == S_IDLE) && !rst;
  assign valid      = (state_q == S_ISSUE);
  assign in         = ((state_q == S_ISSUE) || (state_q == S_WAIT)) ? {a_q, b_q} : 16'd0;
  assign op_codes   = ((state_q == S_ISSUE) || (state_q == S_WAIT)) ? op_q : 2'b00;
  assign res_valid  = (state_q == S_RESP);
  assign res_data   = res_data_q;
  assign res_op     = res_op_q;
  assign res_err    = res_err_q;
  assign issued_cnt = issued_cnt_q;

endmodule
